serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, using a single full-subtractor cell with a registered borrow. It complements the team's combinational full-adder datapath: it is the subtract direction, built serially to trade latency for area. It sits behind a simple start/done handshake so a controller can launch an operation and collect the difference and borrow.

---
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell with registered borrow.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ov.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ov
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sa, sb, sr, sr_nx;
  logic [CW-1:0]    cnt;
  logic             br, br_nx;
  logic             ai, bi, di;
  logic             last, accept;

`ifdef SERIAL_SUB_OVF_EN
  logic am, bm;
`endif

  assign ai     = sa[0];
  assign bi     = sb[0];
  assign di     = ai ^ bi ^ br;
  assign br_nx  = (~ai & bi) | (~(ai ^ bi) & br);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = start && (state != BUSY);
  assign busy   = (state == BUSY);
  assign done   = (state == DONE);

  // Difference bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  if (WIDTH == 1) begin : g_sr1
    assign sr_nx = di;
  end else begin : g_srn
    assign sr_nx = {di, sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    state_nx = start ? BUSY : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      br  <= 1'b0;
      cnt <= '0;
      d   <= '0;
      bo  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am  <= 1'b0;
      bm  <= 1'b0;
      ov  <= 1'b0;
`endif
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      sr  <= '0;
      br  <= 1'b0;
      cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
      am  <= a[WIDTH-1];
      bm  <= b[WIDTH-1];
`endif
    end else if (state == BUSY) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= sr_nx;
      br  <= br_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        d  <= sr_nx;
        bo <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
        ov <= (am ^ bm) & (di ^ am);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed vector bench for serial_subtractor at WIDTH=8.
// Overflow expectations are checked only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, bo;
  logic [W-1:0] d;
`ifdef SERIAL_SUB_OVF_EN
  logic         ov;
`endif

  int ncmp = 0;
  int nbad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ov    (ov)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ov(input string name, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
    check(name, int'(ov), int'(exp));
`else
    if (exp === 1'bx) $display("unexpected x in %s", name);
`endif
  endtask

  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Counts cycles from the accepting edge (cycle 1) until done is seen.
  task automatic wait_done(input int n0, output int lat);
    logic [W-1:0] d0;
    bit busy_bad, d_moved;
    d0 = d;
    busy_bad = 0;
    d_moved = 0;
    lat = n0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (lat > W + 4) begin
        check("done_timeout", lat, W + 1);
        break;
      end
      if (busy !== 1'b1) busy_bad = 1;
      if (d !== d0) d_moved = 1;
      @(posedge clk);
      lat++;
    end
    check("busy_held", int'(busy_bad), 0);
    check("d_stable_busy", int'(d_moved), 0);
  endtask

  initial begin
    int lat;

    vt[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0};
    vt[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vt[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vt[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vt[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vt[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vt[6] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
    vt[7] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_d", int'(d), 0);
    check("rst_bo", int'(bo), 0);
    check_ov("rst_ov", 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      launch(vt[i].a, vt[i].b);
      wait_done(1, lat);
      check($sformatf("v%0d_lat", i), lat, W + 1);
      check($sformatf("v%0d_busy", i), int'(busy), 0);
      check($sformatf("v%0d_d", i), int'(d), int'(vt[i].d));
      check($sformatf("v%0d_bo", i), int'(bo), int'(vt[i].bo));
      check_ov($sformatf("v%0d_ov", i), vt[i].ov);
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), int'({busy, done}), 0);
      check($sformatf("v%0d_hold", i), int'(d), int'(vt[i].d));
    end

    // start during BUSY must not re-latch operands
    launch(8'h05, 8'h03);
    @(posedge clk);
    @(negedge clk);
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3, lat);
    check("ign_lat", lat, W + 1);
    check("ign_d", int'(d), 8'h02);
    check("ign_bo", int'(bo), 0);

    // reset mid-operation aborts with no done
    launch(8'h5A, 8'h23);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_d", int'(d), 0);
    check("abort_bo", int'(bo), 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      bit seen;
      seen = 0;
      repeat (W + 4) begin
        @(negedge clk);
        if (done || busy) seen = 1;
      end
      check("abort_no_done", int'(seen), 0);
    end
    launch(8'h00, 8'h01);
    wait_done(1, lat);
    check("post_lat", lat, W + 1);
    check("post_d", int'(d), 8'hFF);
    check("post_bo", int'(bo), 1);

    // start held high: one result every W+1 cycles
    @(negedge clk);
    a = vt[0].a;
    b = vt[0].b;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      a = vt[k+1].a;
      b = vt[k+1].b;
      wait_done(1, lat);
      check($sformatf("b2b%0d_lat", k), lat, W + 1);
      check($sformatf("b2b%0d_d", k), int'(d), int'(vt[k].d));
      check($sformatf("b2b%0d_bo", k), int'(bo), int'(vt[k].bo));
      check_ov($sformatf("b2b%0d_ov", k), vt[k].ov);
      if (k == 3) start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    check("b2b_idle", int'({busy, done}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
